// File: rtl/alu_reservation_station.sv
// ALU reservation station.
// Holds dispatched ALU ops in a collapsing, age-ordered queue (index 0 is
// the oldest). Operands still pending are woken up from the CDB, and the
// oldest fully ready entry is moved into a registered valid/ready issue port.
module alu_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [CTRL_W-1:0] disp_ctrl,
    input  logic [TAG_W-1:0]  disp_dest_tag,
    input  logic              disp_a_rdy,
    input  logic [TAG_W-1:0]  disp_a_tag,
    input  logic [DATA_W-1:0] disp_a_val,
    input  logic              disp_b_rdy,
    input  logic [TAG_W-1:0]  disp_b_tag,
    input  logic [DATA_W-1:0] disp_b_val,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [CTRL_W-1:0] issue_ctrl,
    output logic [DATA_W-1:0] issue_a,
    output logic [DATA_W-1:0] issue_b,
    output logic [TAG_W-1:0]  issue_dest_tag,
    output logic [CNT_W-1:0]  count
);

    // Registered entry state
    logic              valid_reg [DEPTH];
    logic [CTRL_W-1:0] ctrl_reg  [DEPTH];
    logic [TAG_W-1:0]  dest_reg  [DEPTH];
    logic              a_rdy_reg [DEPTH];
    logic [TAG_W-1:0]  a_tag_reg [DEPTH];
    logic [DATA_W-1:0] a_val_reg [DEPTH];
    logic              b_rdy_reg [DEPTH];
    logic [TAG_W-1:0]  b_tag_reg [DEPTH];
    logic [DATA_W-1:0] b_val_reg [DEPTH];
    logic [CNT_W-1:0]  count_reg;

    // Issue register
    logic              issue_valid_reg;
    logic [CTRL_W-1:0] issue_ctrl_reg;
    logic [DATA_W-1:0] issue_a_reg;
    logic [DATA_W-1:0] issue_b_reg;
    logic [TAG_W-1:0]  issue_dest_reg;

    // Entry state after CDB wakeup, before collapsing
    logic              wk_a_rdy [DEPTH];
    logic [DATA_W-1:0] wk_a_val [DEPTH];
    logic              wk_b_rdy [DEPTH];
    logic [DATA_W-1:0] wk_b_val [DEPTH];

    // Entry state after wakeup and collapsing
    logic              sh_valid [DEPTH];
    logic [CTRL_W-1:0] sh_ctrl  [DEPTH];
    logic [TAG_W-1:0]  sh_dest  [DEPTH];
    logic              sh_a_rdy [DEPTH];
    logic [TAG_W-1:0]  sh_a_tag [DEPTH];
    logic [DATA_W-1:0] sh_a_val [DEPTH];
    logic              sh_b_rdy [DEPTH];
    logic [TAG_W-1:0]  sh_b_tag [DEPTH];
    logic [DATA_W-1:0] sh_b_val [DEPTH];

    logic [DEPTH-1:0]  ready_vec;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              can_load;
    logic              take;
    logic              disp_fire;
    logic [CNT_W-1:0]  wr_idx;

    // Dispatch bypass: operands produced on the dispatch cycle arrive ready
    logic              byp_a_hit;
    logic              byp_b_hit;
    logic              new_a_rdy;
    logic              new_b_rdy;
    logic [DATA_W-1:0] new_a_val;
    logic [DATA_W-1:0] new_b_val;

    assign byp_a_hit = cdb_valid && !disp_a_rdy && (disp_a_tag == cdb_tag);
    assign byp_b_hit = cdb_valid && !disp_b_rdy && (disp_b_tag == cdb_tag);
    assign new_a_rdy = disp_a_rdy || byp_a_hit;
    assign new_b_rdy = disp_b_rdy || byp_b_hit;
    assign new_a_val = byp_a_hit ? cdb_value : disp_a_val;
    assign new_b_val = byp_b_hit ? cdb_value : disp_b_val;

    // Full check uses only registered occupancy, never same-cycle issue
    assign disp_ready = (count_reg < CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign can_load   = !issue_valid_reg || issue_ready;
    assign take       = can_load && sel_found && !flush;
    assign wr_idx     = count_reg - CNT_W'(take);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic a_hit;
            logic b_hit;
            logic write_here;

            assign a_hit = cdb_valid && valid_reg[gi] && !a_rdy_reg[gi] && (a_tag_reg[gi] == cdb_tag);
            assign b_hit = cdb_valid && valid_reg[gi] && !b_rdy_reg[gi] && (b_tag_reg[gi] == cdb_tag);
            assign wk_a_rdy[gi] = a_rdy_reg[gi] || a_hit;
            assign wk_b_rdy[gi] = b_rdy_reg[gi] || b_hit;
            assign wk_a_val[gi] = a_hit ? cdb_value : a_val_reg[gi];
            assign wk_b_val[gi] = b_hit ? cdb_value : b_val_reg[gi];

            // Eligibility uses registered state only, so a wakeup takes a cycle
            assign ready_vec[gi] = valid_reg[gi] && a_rdy_reg[gi] && b_rdy_reg[gi];

            if (gi < DEPTH - 1) begin : g_mid
                logic shift;
                assign shift        = take && (IDX_W'(gi) >= sel_idx);
                assign sh_valid[gi] = shift ? valid_reg[gi+1] : valid_reg[gi];
                assign sh_ctrl[gi]  = shift ? ctrl_reg[gi+1]  : ctrl_reg[gi];
                assign sh_dest[gi]  = shift ? dest_reg[gi+1]  : dest_reg[gi];
                assign sh_a_rdy[gi] = shift ? wk_a_rdy[gi+1]  : wk_a_rdy[gi];
                assign sh_a_tag[gi] = shift ? a_tag_reg[gi+1] : a_tag_reg[gi];
                assign sh_a_val[gi] = shift ? wk_a_val[gi+1]  : wk_a_val[gi];
                assign sh_b_rdy[gi] = shift ? wk_b_rdy[gi+1]  : wk_b_rdy[gi];
                assign sh_b_tag[gi] = shift ? b_tag_reg[gi+1] : b_tag_reg[gi];
                assign sh_b_val[gi] = shift ? wk_b_val[gi+1]  : wk_b_val[gi];
            end else begin : g_last
                // Any removal vacates the top slot
                assign sh_valid[gi] = take ? 1'b0 : valid_reg[gi];
                assign sh_ctrl[gi]  = ctrl_reg[gi];
                assign sh_dest[gi]  = dest_reg[gi];
                assign sh_a_rdy[gi] = wk_a_rdy[gi];
                assign sh_a_tag[gi] = a_tag_reg[gi];
                assign sh_a_val[gi] = wk_a_val[gi];
                assign sh_b_rdy[gi] = wk_b_rdy[gi];
                assign sh_b_tag[gi] = b_tag_reg[gi];
                assign sh_b_val[gi] = wk_b_val[gi];
            end

            assign write_here = disp_fire && (wr_idx == CNT_W'(gi));

            // Entry update: new dispatch, else collapsed/woken contents; flush invalidates
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg[gi] <= 1'b0;
                    ctrl_reg[gi]  <= '0;
                    dest_reg[gi]  <= '0;
                    a_rdy_reg[gi] <= 1'b0;
                    a_tag_reg[gi] <= '0;
                    a_val_reg[gi] <= '0;
                    b_rdy_reg[gi] <= 1'b0;
                    b_tag_reg[gi] <= '0;
                    b_val_reg[gi] <= '0;
                end else begin
                    if (flush) begin
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        valid_reg[gi] <= write_here ? 1'b1 : sh_valid[gi];
                    end
                    if (write_here) begin
                        ctrl_reg[gi]  <= disp_ctrl;
                        dest_reg[gi]  <= disp_dest_tag;
                        a_rdy_reg[gi] <= new_a_rdy;
                        a_tag_reg[gi] <= disp_a_tag;
                        a_val_reg[gi] <= new_a_val;
                        b_rdy_reg[gi] <= new_b_rdy;
                        b_tag_reg[gi] <= disp_b_tag;
                        b_val_reg[gi] <= new_b_val;
                    end else begin
                        ctrl_reg[gi]  <= sh_ctrl[gi];
                        dest_reg[gi]  <= sh_dest[gi];
                        a_rdy_reg[gi] <= sh_a_rdy[gi];
                        a_tag_reg[gi] <= sh_a_tag[gi];
                        a_val_reg[gi] <= sh_a_val[gi];
                        b_rdy_reg[gi] <= sh_b_rdy[gi];
                        b_tag_reg[gi] <= sh_b_tag[gi];
                        b_val_reg[gi] <= sh_b_val[gi];
                    end
                end
            end
        end
    endgenerate

    // Oldest-first select: lowest ready index wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Occupancy counter, excluding the issue register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(disp_fire) - CNT_W'(take);
        end
    end

    // Issue register: load winner when empty or accepted, hold while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_reg <= 1'b0;
            issue_ctrl_reg  <= '0;
            issue_a_reg     <= '0;
            issue_b_reg     <= '0;
            issue_dest_reg  <= '0;
        end else if (flush) begin
            issue_valid_reg <= 1'b0;
        end else if (can_load) begin
            if (sel_found) begin
                issue_valid_reg <= 1'b1;
                issue_ctrl_reg  <= ctrl_reg[sel_idx];
                issue_a_reg     <= a_val_reg[sel_idx];
                issue_b_reg     <= b_val_reg[sel_idx];
                issue_dest_reg  <= dest_reg[sel_idx];
            end else begin
                issue_valid_reg <= 1'b0;
            end
        end
    end

    assign issue_valid    = issue_valid_reg;
    assign issue_ctrl     = issue_ctrl_reg;
    assign issue_a        = issue_a_reg;
    assign issue_b        = issue_b_reg;
    assign issue_dest_tag = issue_dest_reg;
    assign count          = count_reg;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_alu_reservation_station;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int CTRL_W = 16;
    localparam int DATA_W = 64;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [CTRL_W-1:0] disp_ctrl;
    logic [TAG_W-1:0]  disp_dest_tag;
    logic              disp_a_rdy;
    logic [TAG_W-1:0]  disp_a_tag;
    logic [DATA_W-1:0] disp_a_val;
    logic              disp_b_rdy;
    logic [TAG_W-1:0]  disp_b_tag;
    logic [DATA_W-1:0] disp_b_val;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              issue_valid;
    logic              issue_ready;
    logic [CTRL_W-1:0] issue_ctrl;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [TAG_W-1:0]  issue_dest_tag;
    logic [CNT_W-1:0]  count;

    alu_reservation_station #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl),
        .disp_dest_tag(disp_dest_tag),
        .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
        .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b_val(disp_b_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
        .issue_a(issue_a), .issue_b(issue_b), .issue_dest_tag(issue_dest_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [TAG_W-1:0]  dest;
        logic              ar;
        logic [TAG_W-1:0]  at;
        logic [DATA_W-1:0] av;
        logic              br;
        logic [TAG_W-1:0]  bt;
        logic [DATA_W-1:0] bv;
    } ent_t;

    // Reference model: age-ordered queue plus the issue register
    ent_t              q[$];
    logic              m_iv;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;
    logic [TAG_W-1:0]  m_dest;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_iv   = 1'b0;
        m_ctrl = '0;
        m_a    = '0;
        m_b    = '0;
        m_dest = '0;
    endfunction

    // Advance the model by one clock edge using the current inputs
    function automatic void model_step();
        ent_t e;
        int   k;
        bit   room;
        if (flush) begin
            q.delete();
            m_iv = 1'b0;
            return;
        end
        room = (q.size() < DEPTH);
        k = -1;
        for (int i = 0; i < q.size(); i++)
            if (k < 0 && q[i].ar && q[i].br) k = i;
        if (!m_iv || issue_ready) begin
            if (k >= 0) begin
                m_iv   = 1'b1;
                m_ctrl = q[k].ctrl;
                m_a    = q[k].av;
                m_b    = q[k].bv;
                m_dest = q[k].dest;
                q.delete(k);
            end else begin
                m_iv = 1'b0;
            end
        end
        if (cdb_valid) begin
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                if (!e.ar && e.at == cdb_tag) begin e.ar = 1'b1; e.av = cdb_value; end
                if (!e.br && e.bt == cdb_tag) begin e.br = 1'b1; e.bv = cdb_value; end
                q[i] = e;
            end
        end
        if (disp_valid && room) begin
            e.ctrl = disp_ctrl;  e.dest = disp_dest_tag;
            e.ar = disp_a_rdy;   e.at = disp_a_tag;  e.av = disp_a_val;
            e.br = disp_b_rdy;   e.bt = disp_b_tag;  e.bv = disp_b_val;
            if (cdb_valid && !e.ar && e.at == cdb_tag) begin e.ar = 1'b1; e.av = cdb_value; end
            if (cdb_valid && !e.br && e.bt == cdb_tag) begin e.br = 1'b1; e.bv = cdb_value; end
            q.push_back(e);
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the model
    function automatic void check_model();
        chk("issue_valid", 64'(issue_valid), 64'(m_iv));
        chk("count", 64'(count), 64'(q.size()));
        chk("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
        if (m_iv) begin
            chk("issue_ctrl", 64'(issue_ctrl), 64'(m_ctrl));
            chk("issue_a", issue_a, m_a);
            chk("issue_b", issue_b, m_b);
            chk("issue_dest_tag", 64'(issue_dest_tag), 64'(m_dest));
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
        $display("cyc: disp=%0b/%0b cdb=%0b:%0h iss=%0b/%0b dest=%0h cnt=%0d",
                 disp_valid, disp_ready, cdb_valid, cdb_tag, issue_valid, issue_ready,
                 issue_dest_tag, count);
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        disp_ctrl = '0; disp_dest_tag = '0;
        disp_a_rdy = 1'b0; disp_a_tag = '0; disp_a_val = '0;
        disp_b_rdy = 1'b0; disp_b_tag = '0; disp_b_val = '0;
    endtask

    task automatic disp(input logic [TAG_W-1:0] dest,
                        input logic ar, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] av,
                        input logic br, input logic [TAG_W-1:0] bt, input logic [DATA_W-1:0] bv);
        disp_valid = 1'b1; disp_ctrl = CTRL_W'(16'h0A00) | CTRL_W'(dest); disp_dest_tag = dest;
        disp_a_rdy = ar; disp_a_tag = at; disp_a_val = av;
        disp_b_rdy = br; disp_b_tag = bt; disp_b_val = bv;
    endtask

    initial begin
        reset_n = 1'b0;
        issue_ready = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst issue_valid", 64'(issue_valid), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst issue_a", issue_a, 64'd0);
        chk("rst issue_dest", 64'(issue_dest_tag), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst disp_ready", 64'(disp_ready), 64'd1);

        // Both operands ready: issue one edge after dispatch
        issue_ready = 1'b1;
        disp(6'd3, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 64'd7);
        tick();
        idle();
        chk("t1 count E0", 64'(count), 64'd1);
        chk("t1 valid E0", 64'(issue_valid), 64'd0);
        tick();
        chk("t1 valid E1", 64'(issue_valid), 64'd1);
        chk("t1 a", issue_a, 64'd5);
        chk("t1 b", issue_b, 64'd7);
        chk("t1 dest", 64'(issue_dest_tag), 64'd3);
        chk("t1 count E1", 64'(count), 64'd0);
        tick();

        // Younger ready op overtakes an older one waiting on tag 9
        disp(6'd10, 1'b0, 6'd9, 64'd0, 1'b1, 6'd0, 64'd2);
        tick();
        disp(6'd11, 1'b1, 6'd0, 64'd3, 1'b1, 6'd0, 64'd4);
        tick();
        idle();
        tick();
        chk("t2 Y first", 64'(issue_dest_tag), 64'd11);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 64'h1234;
        tick();
        idle();
        chk("t2 gap", 64'(issue_valid), 64'd0);
        tick();
        chk("t2 X valid", 64'(issue_valid), 64'd1);
        chk("t2 X dest", 64'(issue_dest_tag), 64'd10);
        chk("t2 X a", issue_a, 64'h1234);
        tick();

        // Dispatch bypass from a same-cycle broadcast
        disp(6'd12, 1'b1, 6'd0, 64'd2, 1'b0, 6'd4, 64'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_value = 64'd42;
        tick();
        idle();
        tick();
        chk("t3 valid", 64'(issue_valid), 64'd1);
        chk("t3 b", issue_b, 64'd42);
        tick();

        // Fill to capacity while stalled, check hold, full-cycle rejection, drain order
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(6'(20 + i), 1'b1, 6'd0, 64'(100 + i), 1'b1, 6'd0, 64'(i));
            tick();
        end
        idle();
        chk("t4 count full", 64'(count), 64'd4);
        chk("t4 disp_ready", 64'(disp_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4 hold a", issue_a, 64'd100);
            chk("t4 hold dest", 64'(issue_dest_tag), 64'd20);
        end
        issue_ready = 1'b1;
        disp(6'd30, 1'b1, 6'd0, 64'd300, 1'b1, 6'd0, 64'd301);
        tick();
        chk("t5 rejected", 64'(count), 64'd3);
        chk("t5 dest", 64'(issue_dest_tag), 64'd21);
        issue_ready = 1'b0;
        tick();
        chk("t5 accepted", 64'(count), 64'd4);
        idle();
        issue_ready = 1'b1;
        tick();
        chk("t4 drain 22", 64'(issue_dest_tag), 64'd22);
        tick();
        chk("t4 drain 23", 64'(issue_dest_tag), 64'd23);
        tick();
        chk("t4 drain 24", 64'(issue_dest_tag), 64'd24);
        tick();
        chk("t4 drain 30", 64'(issue_dest_tag), 64'd30);
        tick();

        // Flush with a dispatch and a pending handshake
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(6'(40 + i), 1'b1, 6'd0, 64'(i), 1'b1, 6'd0, 64'(i));
            tick();
        end
        chk("t6 pre count", 64'(count), 64'd3);
        chk("t6 pre valid", 64'(issue_valid), 64'd1);
        flush = 1'b1; issue_ready = 1'b1;
        disp(6'd44, 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 64'd1);
        tick();
        idle();
        chk("t6 count", 64'(count), 64'd0);
        chk("t6 valid", 64'(issue_valid), 64'd0);
        chk("t6 disp_ready", 64'(disp_ready), 64'd1);

        // Asynchronous reset in mid-operation
        issue_ready = 1'b0;
        disp(6'd50, 1'b1, 6'd0, 64'd9, 1'b1, 6'd0, 64'd9);
        tick();
        tick();
        idle();
        chk("t7 pre valid", 64'(issue_valid), 64'd1);
        reset_n = 1'b0;
        #2;
        chk("t7 async valid", 64'(issue_valid), 64'd0);
        chk("t7 async count", 64'(count), 64'd0);
        chk("t7 async a", issue_a, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            flush       = ($urandom_range(0, 63) == 0);
            issue_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) begin
                disp(6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), {$urandom, $urandom},
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), {$urandom, $urandom});
                disp_ctrl = CTRL_W'($urandom);
            end
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = 6'($urandom_range(0, 7));
            cdb_value = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side counterpart of the execute-stage ALU. It buffers dispatched ALU ops whose operands may still be pending.
- It captures operand values from the common data bus (CDB) broadcast and selects the oldest fully-ready entry.
- It drives that entry's control bits and both 64-bit operands to the ALU through a registered valid/ready issue port.
- It sits between rename/dispatch and the EX stage.

Parameters:
DEPTH, 4, number of station entries (2..16)
TAG_W, 6, physical-register / ROB tag width
CTRL_W, 16, width of packed control_bits word (usign, aluop, etc.), opaque to this block
DATA_W, 64, operand width (MemoryWord)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept an entry
disp_ctrl  in  CTRL_W  control bits for op
disp_dest_tag  in  TAG_W  result tag
disp_a_rdy  in  1  operand A value valid
disp_a_tag  in  TAG_W  producer tag of A when not ready
disp_a_val  in  DATA_W  operand A value
disp_b_rdy  in  1  operand B value valid
disp_b_tag  in  TAG_W  producer tag of B when not ready
disp_b_val  in  DATA_W  operand B value
cdb_valid  in  1  result broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  DATA_W  broadcast value
issue_valid  out  1  issue register holds an op
issue_ready  in  1  ALU/EX accepts op
issue_ctrl  out  CTRL_W  control bits to ALU
issue_a  out  DATA_W  sourceA to ALU
issue_b  out  DATA_W  sourceB to ALU
issue_dest_tag  out  TAG_W  result tag
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset is asynchronous on reset_n low:
  - All entry valid bits, count and issue_valid go to 0.
  - issue_ctrl/a/b/dest_tag go to 0.
  - disp_ready is 1 on the first cycle after release.
- Storage is a collapsing queue in age order; index 0 is the oldest. Per entry: valid, ctrl, dest_tag, a_rdy/a_tag/a_val, b_rdy/b_tag/b_val.
- disp_ready = (count < DEPTH). It depends only on registered state and never on same-cycle issue. When full, dispatch stalls even if an entry leaves that cycle.
- Dispatch fires when disp_valid && disp_ready. The new entry is appended at index count, or count-1 when an entry is removed on the same edge.
- Wakeup applies when cdb_valid is high. Every valid entry operand with rdy=0 and tag==cdb_tag latches cdb_value and sets rdy=1 at the edge.
- Dispatch bypass: if a dispatched operand has rdy=0 and cdb_valid && cdb_tag matches on the dispatch cycle, it is written already ready with cdb_value.
- Select:
  - Entries are evaluated combinationally each cycle from registered entry state; the lowest index with valid && a_rdy && b_rdy wins.
  - A wakeup at edge N makes an entry eligible in the cycle after N, never the same cycle.
- Issue register:
  - Loads the selected entry when (!issue_valid || issue_ready) and a winner exists. The winner is removed and younger entries shift down on the same edge.
  - If issue_ready && no winner, issue_valid goes to 0.
  - While issue_valid && !issue_ready, all issue_* outputs are held stable and no entry is removed.
- Minimum latency: dispatch with both operands ready at edge E0, then issue_valid=1 after E1.
- CDB does not affect the contents of the issue register; its operands are complete by construction.
- Flush is synchronous and dominates:
  - At the edge, all entries are invalidated, count=0 and issue_valid=0.
  - A dispatch and any pending issue handshake on that cycle are discarded.
- count is the number of valid entries, excluding the issue register.

Test Plan:
- Both operands ready, A=5, B=7, tag 3, issue_ready=1: dispatch edge E0 -> issue_valid=1 after E1 with issue_a=5, issue_b=7, issue_dest_tag=3; count returns to 0.
- Dispatch op X with A pending on tag 9, then op Y fully ready; CDB tag 9 value 0x1234 two cycles later -> Y issues first; X issues with issue_a=0x1234 in the cycle after the wakeup edge.
- Dispatch with B pending on tag 4 while cdb_valid, cdb_tag=4, value 42 on the same cycle -> entry stored ready; issues with issue_b=42 without a further broadcast.
- DEPTH=4, issue_ready=0, 5 ready dispatches -> 1 in issue register plus 4 queued, then disp_ready=0 and count=4; issue outputs stable for 10 cycles; raise issue_ready -> issues drain in dispatch order.
- Full station, issue_ready=1 and disp_valid=1 on the same cycle -> dispatch rejected that cycle (disp_ready=0), accepted next cycle.
- Three entries queued plus issue_valid=1, assert flush with disp_valid=1 -> next cycle count=0, issue_valid=0, disp_ready=1. Assert reset_n low mid-operation -> outputs 0 immediately, without waiting for a clock edge.
